// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencer: steps each instruction through fetch/decode/execute/memory/writeback,
// handles a wait-state memory handshake with timeout, reports faults and counts retirements.
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      ir,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             branch,
    output logic             ir_write,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic [1:0]       mem_to_reg,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } state_e;

    localparam logic [4:0] OpR     = 5'b01100;
    localparam logic [4:0] OpImm   = 5'b00100;
    localparam logic [4:0] OpLoad  = 5'b00000;
    localparam logic [4:0] OpStore = 5'b01000;
    localparam logic [4:0] OpBr    = 5'b11000;
    localparam logic [4:0] OpJal   = 5'b11011;
    localparam logic [4:0] OpJalr  = 5'b11001;
    localparam logic [4:0] OpLui   = 5'b01101;
    localparam logic [4:0] OpAuipc = 5'b00101;

    localparam logic [1:0] FaultIllegal = 2'b01;
    localparam logic [1:0] FaultTimeout = 2'b10;

    // Counter only has to reach MEM_TIMEOUT-1 before the trap fires.
    localparam int unsigned       WaitW    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [WaitW-1:0]  WaitLast = WaitW'(MEM_TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [WaitW-1:0]   wait_q, wait_d;
    logic [1:0]         code_q, code_d;
    logic [CNT_W-1:0]   instret_q, instret_d;

    logic [4:0] opc;
    logic       legal;
    logic       timeout;
    logic       unused_ir;

    assign opc       = ir[6:2];
    assign unused_ir = ^ir[31:7];
    assign timeout   = (MEM_TIMEOUT != 0) && (wait_q == WaitLast);

    always_comb begin
        legal = 1'b0;
        if (ir[1:0] == 2'b11) begin
            case (opc)
                OpR, OpImm, OpLoad, OpStore, OpBr, OpJal, OpJalr, OpLui, OpAuipc: legal = 1'b1;
                default: legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        branch     = 1'b0;
        ir_write   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_write  = 1'b0;
        mem_to_reg = 2'b00;
        retire     = 1'b0;

        case (state_q)
            StFetch: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end else if (timeout) begin
                    state_d = StTrap;
                    code_d  = FaultTimeout;
                end
            end
            StDecode: begin
                if (legal) begin
                    state_d = StExec;
                end else begin
                    state_d = StTrap;
                    code_d  = FaultIllegal;
                end
            end
            StExec: begin
                state_d = StWb;
                case (opc)
                    OpR: alu_op = 2'b10;
                    OpImm: begin
                        alu_src_b = 2'b01;
                        alu_op    = 2'b11;
                    end
                    OpLoad, OpStore: begin
                        alu_src_b = 2'b01;
                        state_d   = StMem;
                    end
                    OpBr: begin
                        alu_op  = 2'b01;
                        branch  = 1'b1;
                        pc_src  = 2'b01;
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                    OpJal, OpJalr: begin
                        pc_write = 1'b1;
                        pc_src   = 2'b10;
                    end
                    OpLui: begin
                        alu_src_a = 2'b10;
                        alu_src_b = 2'b01;
                    end
                    OpAuipc: begin
                        alu_src_a = 2'b01;
                        alu_src_b = 2'b01;
                    end
                    default: begin
                        state_d = StTrap;
                        code_d  = FaultIllegal;
                    end
                endcase
            end
            StMem: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (opc == OpStore);
                if (mem_ready) begin
                    if (opc == OpStore) begin
                        retire  = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end else if (timeout) begin
                    state_d = StTrap;
                    code_d  = FaultTimeout;
                end
            end
            StWb: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
                if (opc == OpLoad) begin
                    mem_to_reg = 2'b01;
                end else if (opc == OpJal || opc == OpJalr) begin
                    mem_to_reg = 2'b10;
                end
            end
            StTrap: state_d = StTrap;
            default: state_d = StFetch;
        endcase

        // Staying in an access state means this was a wait cycle.
        if ((state_q == StFetch || state_q == StMem) && state_d == state_q) begin
            wait_d = wait_q + WaitW'(1);
        end else begin
            wait_d = '0;
        end

        if (rst) begin
            pc_write   = 1'b0;
            pc_src     = 2'b00;
            branch     = 1'b0;
            ir_write   = 1'b0;
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            iord       = 1'b0;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            reg_write  = 1'b0;
            mem_to_reg = 2'b00;
            retire     = 1'b0;
        end

        instret_d = instret_q + CNT_W'(retire);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFetch;
            wait_q    <= '0;
            code_q    <= 2'b00;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            code_q    <= code_d;
            instret_q <= instret_d;
        end
    end

    assign state      = rst ? StFetch : state_q;
    assign fault      = !rst && (state_q == StTrap);
    assign fault_code = rst ? 2'b00 : code_q;
    assign instret    = rst ? '0 : instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed scenarios plus randomized instructions and wait states,
// compared every cycle against an instruction-level behavioural model.
module tb_multicycle_control;

    localparam int unsigned TMO = 4;
    localparam int unsigned CW  = 4;

    localparam int CL_R = 0, CL_I = 1, CL_LD = 2, CL_ST = 3, CL_BR = 4;
    localparam int CL_JAL = 5, CL_JALR = 6, CL_LUI = 7, CL_AUIPC = 8, CL_ILL = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   ir = 32'h0;
    logic          mem_ready = 1'b0;
    logic          pc_write, branch, ir_write, mem_req, mem_we, iord, reg_write, fault, retire;
    logic [1:0]    pc_src, alu_src_a, alu_src_b, alu_op, mem_to_reg, fault_code;
    logic [CW-1:0] instret;
    logic [2:0]    state;

    logic [31:0]   fetch_word = 32'h0;
    int            n_chk = 0;
    int            n_fail = 0;

    // Model: which step of the instruction we are in, wait cycles seen, retire count, fault code.
    int            m_st = 0;
    int            m_wait = 0;
    logic [CW-1:0] m_cnt = '0;
    logic [1:0]    m_code = 2'b00;

    multicycle_control #(
        .MEM_TIMEOUT(TMO),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ir        (ir),
        .mem_ready (mem_ready),
        .pc_write  (pc_write),
        .pc_src    (pc_src),
        .branch    (branch),
        .ir_write  (ir_write),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .iord      (iord),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .reg_write (reg_write),
        .mem_to_reg(mem_to_reg),
        .fault     (fault),
        .fault_code(fault_code),
        .retire    (retire),
        .instret   (instret),
        .state     (state)
    );

    always #5 clk = ~clk;

    function automatic int cls_of(input logic [31:0] w);
        if (w[1:0] != 2'b11) return CL_ILL;
        case (w[6:2])
            5'b01100: return CL_R;
            5'b00100: return CL_I;
            5'b00000: return CL_LD;
            5'b01000: return CL_ST;
            5'b11000: return CL_BR;
            5'b11011: return CL_JAL;
            5'b11001: return CL_JALR;
            5'b01101: return CL_LUI;
            5'b00101: return CL_AUIPC;
            default:  return CL_ILL;
        endcase
    endfunction

    // {pc_write, pc_src, branch, alu_src_a, alu_src_b, alu_op} during execute
    function automatic logic [9:0] exec_ctl(input int cl);
        case (cl)
            CL_R:           return 10'b0_00_0_00_00_10;
            CL_I:           return 10'b0_00_0_00_01_11;
            CL_LD, CL_ST:   return 10'b0_00_0_00_01_00;
            CL_BR:          return 10'b0_01_1_00_00_01;
            CL_JAL, CL_JALR: return 10'b1_10_0_00_00_00;
            CL_LUI:         return 10'b0_00_0_10_01_00;
            CL_AUIPC:       return 10'b0_00_0_01_01_00;
            default:        return 10'b0;
        endcase
    endfunction

    function automatic int after_exec(input int cl);
        if (cl == CL_BR) return 0;
        if (cl == CL_LD || cl == CL_ST) return 3;
        return 4;
    endfunction

    function automatic logic [23:0] exp_vec(input int st, input int cl, input logic rdy,
                                            input logic r, input logic [1:0] code);
        logic       pcw, br, irw, mrq, mwe, io, rw, flt, rt;
        logic [1:0] src, a, b, op, m2r, fc;
        logic [2:0] se;
        {pcw, br, irw, mrq, mwe, io, rw, flt, rt} = '0;
        {src, a, b, op, m2r, fc} = '0;
        se = 3'(st);
        case (st)
            0: begin mrq = 1'b1; irw = rdy; pcw = rdy; end
            2: begin {pcw, src, br, a, b, op} = exec_ctl(cl); rt = (cl == CL_BR); end
            3: begin mrq = 1'b1; io = 1'b1; mwe = (cl == CL_ST); rt = rdy && (cl == CL_ST); end
            4: begin
                rw = 1'b1;
                rt = 1'b1;
                m2r = (cl == CL_LD) ? 2'b01 : (cl == CL_JAL || cl == CL_JALR) ? 2'b10 : 2'b00;
            end
            5: begin flt = 1'b1; fc = code; end
            default: ;
        endcase
        if (r) return 24'h0;
        return {pcw, src, br, irw, mrq, mwe, io, a, b, op, rw, m2r, flt, fc, rt, se};
    endfunction

    function automatic logic [31:0] gen_word();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 9))
            0: w[6:0] = 7'b0110011;
            1: w[6:0] = 7'b0010011;
            2: w[6:0] = 7'b0000011;
            3: w[6:0] = 7'b0100011;
            4: w[6:0] = 7'b1100011;
            5: w[6:0] = 7'b1101111;
            6: w[6:0] = 7'b1100111;
            7: w[6:0] = 7'b0110111;
            8: w[6:0] = 7'b0010111;
            default: begin
                if ($urandom_range(0, 1) == 0) w[6:0] = 7'h7F;
                else w[1:0] = 2'($urandom_range(0, 2));
            end
        endcase
        return w;
    endfunction

    // Behavioural model and the instruction register the datapath would hold.
    always @(posedge clk) begin
        int cl;
        cl = cls_of(ir);
        if (rst) begin
            m_st <= 0; m_wait <= 0; m_cnt <= '0; m_code <= 2'b00;
        end else begin
            if (exp_vec(m_st, cl, mem_ready, 1'b0, m_code)[3]) m_cnt <= m_cnt + 1'b1;
            if (m_st == 0 && mem_ready) ir <= fetch_word;
            case (m_st)
                0, 3: begin
                    if (mem_ready) begin
                        m_st   <= (m_st == 0) ? 1 : ((cl == CL_ST) ? 0 : 4);
                        m_wait <= 0;
                    end else if (TMO != 0 && m_wait + 1 == int'(TMO)) begin
                        m_st <= 5; m_code <= 2'b10;
                    end else begin
                        m_wait <= m_wait + 1;
                    end
                end
                1: if (cl == CL_ILL) begin m_st <= 5; m_code <= 2'b01; end else m_st <= 2;
                2: begin m_st <= after_exec(cl); m_wait <= 0; end
                4: begin m_st <= 0; m_wait <= 0; end
                default: ;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [23:0] dut_vec;
    assign dut_vec = {pc_write, pc_src, branch, ir_write, mem_req, mem_we, iord, alu_src_a,
                      alu_src_b, alu_op, reg_write, mem_to_reg, fault, fault_code, retire, state};

    always @(negedge clk) begin
        chk("outputs", 32'(dut_vec), 32'(exp_vec(m_st, cls_of(ir), mem_ready, rst, m_code)));
        chk("instret", 32'(instret), rst ? 32'h0 : 32'(m_cnt));
    end

    task automatic drive(input logic r, input logic rdy);
        @(posedge clk);
        #1;
        rst = r;
        mem_ready = rdy;
        #4;
    endtask

    task automatic reset2();
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
    endtask

    // Drive n cycles with ready from rdy[i], checking the state from nibble i of sts.
    task automatic walk(input string tag, input int n, input logic [31:0] rdy,
                        input logic [63:0] sts);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, rdy[i]);
            chk(tag, 32'(state), 32'(sts[4*i +: 4]));
        end
    endtask

    initial begin
        reset2();
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_mem_req", 32'(mem_req), 32'd0);
        chk("reset_instret", 32'(instret), 32'd0);

        fetch_word = 32'h002081B3;
        walk("r_states", 4, 32'hF, 64'h4210);
        chk("r_reg_write", 32'(reg_write), 32'd1);
        chk("r_retire", 32'(retire), 32'd1);
        chk("r_instret_before", 32'(instret), 32'd0);
        walk("r_back", 1, 32'h1, 64'h0);
        chk("r_instret_after", 32'(instret), 32'd1);

        reset2();
        fetch_word = 32'h008000EF;
        walk("jal_states", 3, 32'hF, 64'h210);
        chk("jal_pc_write", 32'(pc_write), 32'd1);
        chk("jal_pc_src", 32'(pc_src), 32'd2);
        walk("jal_wb", 1, 32'h1, 64'h4);
        chk("jal_mem_to_reg", 32'(mem_to_reg), 32'd2);
        chk("jal_reg_write", 32'(reg_write), 32'd1);

        reset2();
        fetch_word = 32'h0000A283;
        walk("lw_states", 7, 32'h47, 64'h3333210);
        chk("lw_iord", 32'(iord), 32'd1);
        chk("lw_no_retire_yet", 32'(retire), 32'd0);
        walk("lw_wb", 1, 32'h1, 64'h4);
        chk("lw_mem_to_reg", 32'(mem_to_reg), 32'd1);
        chk("lw_retire_cycle8", 32'(retire), 32'd1);

        reset2();
        fetch_word = 32'h00000063;
        walk("tmo_edge_states", 6, 32'h38, 64'h210000);
        chk("tmo_edge_retire", 32'(retire), 32'd1);
        chk("tmo_edge_fault", 32'(fault), 32'd0);

        reset2();
        walk("tmo_states", 5, 32'h0, 64'h50000);
        chk("tmo_fault", 32'(fault), 32'd1);
        chk("tmo_code", 32'(fault_code), 32'd2);
        chk("tmo_mem_req", 32'(mem_req), 32'd0);
        walk("tmo_hold", 2, 32'h3, 64'h55);

        reset2();
        fetch_word = 32'h0000007F;
        walk("ill_states", 3, 32'h7, 64'h510);
        chk("ill_code", 32'(fault_code), 32'd1);
        chk("ill_fault", 32'(fault), 32'd1);
        chk("ill_reg_write", 32'(reg_write), 32'd0);
        walk("ill_hold", 3, 32'h7, 64'h555);
        chk("ill_mem_req", 32'(mem_req), 32'd0);

        reset2();
        fetch_word = 32'h002081B3;
        walk("mid_r", 4, 32'hF, 64'h4210);
        fetch_word = 32'h0000A283;
        walk("mid_lw", 5, 32'h7, 64'h33210);
        chk("mid_instret", 32'(instret), 32'd1);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0);
            chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
            chk("mid_rst_iord", 32'(iord), 32'd0);
            chk("mid_rst_instret", 32'(instret), 32'd0);
        end
        drive(1'b0, 1'b0);
        chk("mid_rel_state", 32'(state), 32'd0);
        chk("mid_rel_mem_req", 32'(mem_req), 32'd1);
        chk("mid_rel_instret", 32'(instret), 32'd0);

        for (int i = 0; i < 4000; i++) begin
            logic r;
            fetch_word = gen_word();
            r = ($urandom_range(0, 299) == 0) || (m_st == 5 && $urandom_range(0, 3) == 0);
            drive(r, $urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequencing controller for the multi-cycle RV32I core. It replaces per-instruction combinational decode with a state machine that steps each instruction through fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one memory port. It handles a wait-state memory handshake with a configurable timeout, fully decodes JAL, LUI and AUIPC, reports faults, and counts retired instructions.

## Interface
- `MEM_TIMEOUT`, default 15: maximum `mem_ready` wait cycles per access; 0 disables the timeout.
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ir` in 32: instruction register contents, stable except when `ir_write` is high.
- `mem_ready` in 1: memory completes the current access in this cycle.
- `pc_write` out 1: load PC from the source selected by `pc_src`.
- `pc_src` out 2: 00 = PC+4, 01 = branch target, 10 = jump target (JAL: PC+immJ; JALR: rs1+immI).
- `branch` out 1: conditional PC load; the datapath ANDs it with ALU zero.
- `ir_write` out 1: latch memory read data into IR.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: store write enable; asserted only together with `mem_req`.
- `iord` out 1: memory address select, 0 = PC, 1 = ALU result.
- `alu_src_a` out 2: ALU operand A, 00 = rs1, 01 = PC, 10 = zero.
- `alu_src_b` out 2: ALU operand B, 00 = rs2, 01 = immediate, 10 = constant 4.
- `alu_op` out 2: 00 = add, 01 = branch compare, 10 = R-type funct, 11 = I-type funct.
- `reg_write` out 1: register-file write enable.
- `mem_to_reg` out 2: writeback source, 00 = ALU result, 01 = memory data, 10 = PC+4.
- `fault` out 1: sticky fault flag.
- `fault_code` out 2: 01 = illegal opcode, 10 = memory timeout.
- `retire` out 1: one-cycle pulse when an instruction completes.
- `instret` out CNT_W: count of retired instructions.
- `state` out 3: current state encoding, exported for debug.

## Operation
- States and encodings: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 5.
- **Output style.** Outputs decode combinationally from the registered state and `ir[6:0]`. Strobes qualified by `mem_ready` are Mealy outputs. Any output not driven by the active state is 0.
- **FETCH:**
  - Drives `mem_req=1`, `iord=0`.
  - When `mem_ready=1`: `ir_write=1`, `pc_write=1`, `pc_src=00`, then go to DECODE.
- **DECODE:** illegal when `ir[1:0]` is not 11, or when `ir[6:2]` is not one of 01100, 00100, 00000, 01000, 11000, 11011, 11001, 01101, 00101. Illegal goes to TRAP with code 01; otherwise go to EXEC.
- **EXEC by opcode:**
  - R-type: A=rs1, B=rs2, `alu_op=10`, then WB.
  - I-ALU: A=rs1, B=imm, `alu_op=11`, then WB.
  - Load and store: A=rs1, B=imm, `alu_op=00`, then MEM.
  - Branch: A=rs1, B=rs2, `alu_op=01`, `branch=1`, `pc_src=01`, then FETCH with `retire`.
  - JAL and JALR: `pc_write=1`, `pc_src=10`, then WB.
  - LUI: A=zero, B=imm, add, then WB.
  - AUIPC: A=PC, B=imm, add, then WB.
- **MEM:**
  - Drives `mem_req=1`, `iord=1`, `mem_we=1` for stores.
  - On `mem_ready`, a store goes to FETCH with `retire`; a load goes to WB.
- **WB:**
  - `reg_write=1`. `mem_to_reg` = 01 for loads, 10 for JAL/JALR, 00 otherwise.
  - Then go to FETCH with `retire`.
- **Wait counter.** Resets to 0 on entry to FETCH or MEM and increments each cycle `mem_ready=0`. If `MEM_TIMEOUT>0` and the counter reaches `MEM_TIMEOUT` while `mem_ready=0`, go to TRAP with code 10.
- **TRAP:**
  - Holds until reset with `fault=1` and all strobes 0.
  - `fault_code` is latched on TRAP entry.
- **instret:** increments by 1 on each `retire` and wraps modulo 2^CNT_W.

## Timing
- **Reset.** While `rst=1`: state = FETCH, `instret=0`, `fault=0`, `fault_code=00`, wait counter 0, and every strobe output forced to 0. FETCH requests memory from the first cycle after `rst` falls.
- **Reset mid-access.** Reset in any state, including TRAP or mid-wait, returns to FETCH on the next edge. The access in flight is abandoned and `instret` clears.
- **Latency at zero wait states:**
  - Branch: 3 cycles.
  - R, I-ALU, LUI, AUIPC, JAL, JALR: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- **Wait states.** Each cycle of `mem_ready=0` adds 1 cycle to FETCH or MEM.
- **Timeout boundary.** With `MEM_TIMEOUT=N`, `mem_ready` arriving on wait cycle N-1 (counting from 0) completes normally. N consecutive low cycles trap.
- **Ignored `mem_ready`.** `mem_ready` is ignored outside FETCH and MEM.
- **Retire.** `retire` is high in the final cycle of an instruction; `instret` shows the new value on the following cycle.

## Test plan
- **Reset mid-access.** Hold `rst` for 2 cycles during a MEM wait -> outputs all 0, `instret=0`, `state=0` after release.
- **R-type, zero wait.** `ir=0x002081B3` (add x3,x1,x2) with `mem_ready=1` -> states 0,1,2,4; `reg_write` in cycle 4; `instret` goes 0 -> 1.
- **Load with waits.** lw with `mem_ready` low 3 cycles in MEM -> 8 cycles total; `iord=1`, `mem_to_reg=01` in WB.
- **JAL.** `ir=0x008000EF` -> EXEC has `pc_write=1`, `pc_src=10`; WB has `mem_to_reg=10`, `reg_write=1`.
- **Illegal opcode.** `ir=0x0000007F` -> TRAP after DECODE, `fault_code=01`, no `reg_write` or `mem_req` ever asserted; persists until `rst`.
- **Fetch timeout.** `MEM_TIMEOUT=4`, `mem_ready` held 0 in FETCH -> TRAP after 4 cycles with `fault_code=10`; a repeat run with ready on wait cycle 3 completes normally.
